// File: rtl/mmr_uart_tx_pkg.sv
// Shared state encoding, control-register bit positions and counter sizing for mmr_uart_tx.
package mmr_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CHECK,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    localparam int CTL_GO_BIT = 0;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mmr_uart_tx_baud_tick.sv
// Bit-period down-counter: tick while the count is 0, then reload CLK_DIV-1; load restarts a bit.
// Free-running with no backpressure; tick is combinational from the count flop.
module mmr_uart_tx_baud_tick
    import mmr_uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (load || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/mmr_uart_tx.sv
// 8N1 transmitter fed by data/control MMR side ports; txd falls 3 cycles after the IDLE cycle that sees GO.
// No backpressure: GO is not sampled while busy, a pending GO is served in the first IDLE cycle.
module mmr_uart_tx
    import mmr_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MMR_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 data_re,
    inout  wire  [MMR_WIDTH-1:0] data_val,
    output logic                 ctl_re,
    output logic                 ctl_we,
    inout  wire  [MMR_WIDTH-1:0] ctl_val,
    output logic                 txd,
    output logic                 busy
);

    localparam int CW = clog2(DATA_WIDTH + 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    ctl_we_q, ctl_we_d;
    logic                    baud_load;
    logic                    baud_tick;
    logic                    unused_bits;

    mmr_uart_tx_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (baud_load),
        .tick    (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctl_val[CTL_GO_BIT]) begin
                    shift_d = data_val[DATA_WIDTH-1:0];
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_CHECK;
            // A bus write that beat our clear leaves GO set: clear again, keep the latched byte.
            ST_CHECK: begin
                if (ctl_val[CTL_GO_BIT]) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d   = ST_START;
                    baud_load = 1'b1;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        ctl_we_d = (state_d == ST_CLEAR);
        busy_d   = (state_d != ST_IDLE);
        txd_d    = 1'b1;
        if (state_d == ST_START) begin
            txd_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            txd_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ctl_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ctl_we_q  <= ctl_we_d;
        end
    end

    assign data_re = 1'b1;
    assign ctl_re  = !ctl_we_q;
    assign ctl_we  = ctl_we_q;
    assign ctl_val = ctl_we_q ? '0 : 'z;
    assign txd     = txd_q;
    assign busy    = busy_q;

    assign unused_bits = ^{data_val[MMR_WIDTH-1:DATA_WIDTH], ctl_val[MMR_WIDTH-1:CTL_GO_BIT+1]};

endmodule

// File: tb/tb_mmr_uart_tx.sv
// Bench for mmr_uart_tx: MMR models on both side ports, a serial frame decoder and a byte scoreboard.
module tb_mmr_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = (8 + 2) * CLK_DIV;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_re, ctl_re, ctl_we, txd, busy;
    wire  [31:0] data_val;
    wire  [31:0] ctl_val;

    logic [31:0] data_reg = 32'hDEAD_BEEF;
    logic [31:0] ctl_reg  = 32'h8000_0000;
    logic        sw_wr    = 1'b0;
    logic [31:0] sw_val   = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, we_cnt = 0, frames_done = 0, mon_cnt = 0;
    int fall_cyc = 0, busy_fall_cyc = 0, gap = 0;
    logic txd_prev  = 1'b1;
    logic busy_prev = 1'b0;
    logic samples [FRAME];
    logic [7:0] sb_q [$];

    mmr_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (8),
        .MMR_WIDTH  (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_re  (data_re),
        .data_val (data_val),
        .ctl_re   (ctl_re),
        .ctl_we   (ctl_we),
        .ctl_val  (ctl_val),
        .txd      (txd),
        .busy     (busy)
    );

    assign data_val = data_re ? data_reg : 32'hz;
    assign ctl_val  = ctl_re  ? ctl_reg  : 32'hz;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Control register: bus writes win over the side-port write on the same negedge.
    always @(negedge clk) begin
        if (sw_wr) begin
            ctl_reg <= sw_val;
        end else if (ctl_we) begin
            ctl_reg <= ctl_val;
        end
        if (ctl_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame();
        logic       ok;
        logic [7:0] b;
        ok = 1'b1;
        for (int k = 0; k < CLK_DIV; k++) begin
            if (samples[k] !== 1'b0) ok = 1'b0;
            if (samples[FRAME-1-k] !== 1'b1) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = samples[CLK_DIV*(i+1)];
            for (int k = 0; k < CLK_DIV; k++) begin
                if (samples[CLK_DIV*(i+1)+k] !== b[i]) ok = 1'b0;
            end
        end
        frames_done++;
        check_eq("frame_shape", ok, 1);
        check_eq("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) check_eq("frame_data", b, sb_q.pop_front());
    endtask

    // Serial decoder: one sample per cycle from the start-bit falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_cnt = 0;
        end else if (mon_cnt == 0) begin
            if (txd_prev && !txd) begin
                samples[0] = txd;
                mon_cnt    = 1;
                fall_cyc   = cyc;
                gap        = cyc - busy_fall_cyc;
            end
        end else begin
            samples[mon_cnt] = txd;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                mon_cnt = 0;
                check_frame();
            end
        end
        txd_prev = txd;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
    end

    task automatic sw_go(output int e);
        @(posedge clk);
        #1;
        sw_val = 32'h1;
        sw_wr  = 1'b1;
        e      = cyc;
        @(negedge clk);
        #1;
        sw_wr  = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int budget;
        budget = 200;
        while (frames_done < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        check_eq(tag, frames_done, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int e, e2, f0, w0;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_txd", txd, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ctl_we", ctl_we, 0);
        check_eq("rst_ctl_re", ctl_re, 1);
        check_eq("rst_data_re", data_re, 1);
        check_eq("rst_ctl_val", ctl_val, 32'h8000_0000);
        check_eq("rst_data_val", data_val, 32'hDEAD_BEEF);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic frame
        data_reg = 32'h0000_00A5;
        sb_q.push_back(8'hA5);
        f0 = frames_done;
        w0 = we_cnt;
        sw_go(e);
        check_eq("basic_we_pre", ctl_we, 0);
        @(negedge clk); #1;
        check_eq("basic_we_on", ctl_we, 1);
        @(negedge clk); #1;
        check_eq("basic_we_off", ctl_we, 0);
        wait_frames(f0 + 1, "basic_timeout");
        check_eq("basic_fall", fall_cyc, e + 3);
        repeat (3) @(negedge clk);
        #1;
        check_eq("basic_busy_fall", busy_fall_cyc, e + 3 + FRAME);
        check_eq("basic_ctl_clr", ctl_reg, 0);
        check_eq("basic_we_pulses", we_cnt - w0, 1);

        // Collision: bus GO lands on the clear cycle, data changes too
        data_reg = 32'h0000_00C3;
        sb_q.push_back(8'hC3);
        f0 = frames_done;
        w0 = we_cnt;
        sw_go(e);
        @(posedge clk);
        #1;
        sw_wr    = 1'b1;
        data_reg = 32'h0000_0011;
        @(negedge clk);
        #1;
        sw_wr    = 1'b0;
        wait_frames(f0 + 1, "coll_timeout");
        check_eq("coll_fall", fall_cyc, e + 5);
        check_eq("coll_we_pulses", we_cnt - w0, 2);
        repeat (2 * FRAME) @(negedge clk);
        #1;
        check_eq("coll_one_frame", frames_done, f0 + 1);

        // Mid-frame request
        data_reg = 32'h0000_00A5;
        sb_q.push_back(8'hA5);
        f0 = frames_done;
        sw_go(e);
        repeat (20) @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1);
        data_reg = 32'h0000_003C;
        sb_q.push_back(8'h3C);
        sw_go(e2);
        wait_frames(f0 + 2, "mid_timeout");
        check_eq("mid_gap", gap, 3);

        // Reset during the fourth data bit (bit 3 of 0x52 is 0)
        repeat (10) @(posedge clk);
        data_reg = 32'h0000_0052;
        f0 = frames_done;
        sw_go(e);
        repeat (20) @(posedge clk);
        #1;
        check_eq("rstmid_txd_pre", txd, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstmid_txd", txd, 1);
        check_eq("rstmid_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        #1;
        check_eq("rstmid_no_frame", frames_done, f0);
        check_eq("rstmid_idle_txd", txd, 1);
        check_eq("rstmid_idle_busy", busy, 0);

        // Upper data bits ignored
        data_reg = 32'hFFFF_FF00;
        sb_q.push_back(8'h00);
        f0 = frames_done;
        sw_go(e);
        wait_frames(f0 + 1, "upper_timeout");
        check_eq("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
